add_cla_pipe: RTL

Parametrised, pipelined carry-lookahead adder/subtractor for the floating-point datapath's mantissa and exponent paths. The WIDTH-bit operation is split into BLOCK-bit lookahead groups, with one pipeline rank per group. The carry passes between groups through registers, so the clock period is bounded by a single BLOCK-bit lookahead. A valid/ready handshake with full-pipeline stall lets it sit between the alignment shifter and the normaliser.

---
 rtl/add_cla_pipe_if.sv | 38 +++
 rtl/add_cla_pipe.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/add_cla_pipe_if.sv
// Handshake and data bundle for add_cla_pipe; oZ exists only with ADD_CLA_PIPE_ZERO_EN.
// The master modport is the upstream/downstream side, the slave modport is the adder.
interface add_cla_pipe_if #(
  parameter int unsigned WIDTH = 24
) ();
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iC;
  logic             iSub;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oS;
  logic             oC;
  logic             oOvf;
`ifdef ADD_CLA_PIPE_ZERO_EN
  logic             oZ;

  modport master (
    output iValid, iA, iB, iC, iSub, iReady,
    input  oReady, oValid, oS, oC, oOvf, oZ
  );
  modport slave (
    input  iValid, iA, iB, iC, iSub, iReady,
    output oReady, oValid, oS, oC, oOvf, oZ
  );
`else
  modport master (
    output iValid, iA, iB, iC, iSub, iReady,
    input  oReady, oValid, oS, oC, oOvf
  );
  modport slave (
    input  iValid, iA, iB, iC, iSub, iReady,
    output oReady, oValid, oS, oC, oOvf
  );
`endif
endinterface

// File: rtl/add_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per rank, with
// full-pipeline stall. Define ADD_CLA_PIPE_ZERO_EN to add the registered zero flag oZ.
module add_cla_pipe #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned BLOCK = 8
) (
  input logic           iClk,
  input logic           iRst_n,
  add_cla_pipe_if.slave bus
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  // Subtract is A + ~B + ~borrow; the inversion happens once, before the operands are skewed.
  assign b_eff   = bus.iB ^ {WIDTH{bus.iSub}};
  assign cin_eff = bus.iC ^ bus.iSub;

  for (genvar k = 0; k < NBLK; k++) begin : g_rank
    logic [BLOCK-1:0]       grp_a;
    logic [BLOCK-1:0]       grp_b;
    logic                   grp_cin;
    logic                   vld_in;
    logic [BLOCK-1:0]       gen;
    logic [BLOCK-1:0]       prop;
    logic [BLOCK-1:0]       pre_g;
    logic [BLOCK-1:0]       pre_p;
    logic [BLOCK:0]         c;
    logic [BLOCK-1:0]       sum;
    logic                   vld_q;
    logic                   cout_q;
    logic [(k+1)*BLOCK-1:0] res_d;
    logic [(k+1)*BLOCK-1:0] res_q;

    if (k == 0) begin : g_src
      assign grp_a   = bus.iA[BLOCK-1:0];
      assign grp_b   = b_eff[BLOCK-1:0];
      assign grp_cin = cin_eff;
      assign vld_in  = bus.iValid;
      assign res_d   = sum;
    end else begin : g_src
      assign grp_a   = g_rank[k-1].g_fwd.a_q[BLOCK-1:0];
      assign grp_b   = g_rank[k-1].g_fwd.b_q[BLOCK-1:0];
      assign grp_cin = g_rank[k-1].cout_q;
      assign vld_in  = g_rank[k-1].vld_q;
      assign res_d   = {sum, g_rank[k-1].res_q};
    end

    // Group generate/propagate prefixes do not depend on the carry-in, so the late registered
    // carry only passes through the final AND-OR of each bit.
    always_comb begin
      gen      = grp_a & grp_b;
      prop     = grp_a ^ grp_b;
      pre_g    = '0;
      pre_p    = '0;
      c        = '0;
      pre_g[0] = gen[0];
      pre_p[0] = prop[0];
      c[0]     = grp_cin;
      for (int i = 1; i < BLOCK; i++) begin
        pre_g[i] = gen[i] | (prop[i] & pre_g[i-1]);
        pre_p[i] = prop[i] & pre_p[i-1];
      end
      for (int i = 0; i < BLOCK; i++) begin
        c[i+1] = pre_g[i] | (pre_p[i] & grp_cin);
      end
      sum = prop ^ c[BLOCK-1:0];
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        vld_q  <= 1'b0;
        cout_q <= 1'b0;
        res_q  <= '0;
      end else if (en) begin
        vld_q  <= vld_in;
        cout_q <= c[BLOCK];
        res_q  <= res_d;
      end
    end

    // Operand groups not yet consumed travel alongside, skewed one rank per group.
    if (k < NBLK - 1) begin : g_fwd
      localparam int unsigned FwdW = WIDTH - (k + 1) * BLOCK;

      logic [FwdW-1:0] a_d;
      logic [FwdW-1:0] b_d;
      logic [FwdW-1:0] a_q;
      logic [FwdW-1:0] b_q;

      if (k == 0) begin : g_op
        assign a_d = bus.iA[WIDTH-1:BLOCK];
        assign b_d = b_eff[WIDTH-1:BLOCK];
      end else begin : g_op
        assign a_d = g_rank[k-1].g_fwd.a_q[WIDTH-k*BLOCK-1:BLOCK];
        assign b_d = g_rank[k-1].g_fwd.b_q[WIDTH-k*BLOCK-1:BLOCK];
      end

      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef ADD_CLA_PIPE_ZERO_EN
    logic zero_d;
    logic zero_q;

    if (k == 0) begin : g_zero
      assign zero_d = ~|sum;
    end else begin : g_zero
      assign zero_d = g_rank[k-1].zero_q & ~|sum;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        zero_q <= 1'b0;
      end else if (en) begin
        zero_q <= zero_d;
      end
    end
`endif
  end

  // Overflow compares the carries into and out of the sign bit, both local to the top group.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= g_rank[NBLK-1].c[BLOCK-1] ^ g_rank[NBLK-1].c[BLOCK];
    end
  end

  assign en         = ~g_rank[NBLK-1].vld_q | bus.iReady;
  assign bus.oReady = en;
  assign bus.oValid = g_rank[NBLK-1].vld_q;
  assign bus.oS     = g_rank[NBLK-1].res_q;
  assign bus.oC     = g_rank[NBLK-1].cout_q;
  assign bus.oOvf   = ovf_q;
`ifdef ADD_CLA_PIPE_ZERO_EN
  assign bus.oZ     = g_rank[NBLK-1].zero_q;
`endif

endmodule
